// File: rtl/time_mgr_multi_hb.sv
// Time manager: programmable-length time units, PC-throttled advance and NHB heartbeat channels.
// Build with TIME_MGR_SLACK_EN defined to add the max_lead run-ahead input.
module time_mgr_multi_hb #(
  parameter int NUNIT  = 16,
  parameter int NTIME  = 48,
  parameter int NHB    = 4,
  parameter int NHBDIV = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUNIT-1:0]      unit_len,
  input  logic                  reset_time,
  input  logic [NTIME-1:0]      pc_time_elapsed,
`ifdef TIME_MGR_SLACK_EN
  input  logic [NTIME-1:0]      max_lead,
`endif
  input  logic [NHB*NHBDIV-1:0] hb_every,
  output logic                  unit_pulse,
  output logic [NTIME-1:0]      time_elapsed,
  output logic [NHB-1:0]        hb_pulse,
  output logic                  stall_dn
);

  typedef enum logic {COUNT, HOLD} state_t;

  state_t           state;
  logic [NUNIT-1:0] unit_cnt;
  logic [NUNIT-1:0] term_val;
  logic [NTIME-1:0] limit;
  logic             terminal;
  logic             ahead;
  logic             advance;
  logic             zero_stall;

`ifdef TIME_MGR_SLACK_EN
  assign limit = pc_time_elapsed + max_lead;
`else
  assign limit = pc_time_elapsed;
`endif

  // unit_len of 0 behaves like 1; a shrunken unit_len counts as terminal at once
  always_comb begin
    term_val   = (unit_len == '0) ? '0 : unit_len - 1'b1;
    terminal   = (state == HOLD) || (unit_cnt >= term_val);
    ahead      = (time_elapsed >= limit);
    advance    = terminal && !ahead;
    zero_stall = (term_val == '0) && (limit == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= COUNT;
      unit_cnt     <= '0;
      time_elapsed <= '0;
      unit_pulse   <= 1'b0;
      stall_dn     <= 1'b1;
    end else if (reset_time) begin
      state        <= COUNT;
      unit_cnt     <= '0;
      time_elapsed <= '0;
      unit_pulse   <= 1'b0;
      stall_dn     <= zero_stall;
    end else begin
      unit_pulse <= advance;
      stall_dn   <= terminal && ahead;
      if (advance) begin
        state        <= COUNT;
        unit_cnt     <= '0;
        time_elapsed <= time_elapsed + 1'b1;
      end else if (terminal) begin
        state <= HOLD;
      end else begin
        unit_cnt <= unit_cnt + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NHB; gi++) begin : g_hb
      logic [NHBDIV-1:0] every;
      logic [NHBDIV-1:0] hb_cnt;
      logic              pulse;

      assign every        = hb_every[gi*NHBDIV +: NHBDIV];
      assign hb_pulse[gi] = pulse;

      // >= rather than == so a period lowered below the count fires on the next advance
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hb_cnt <= '0;
          pulse  <= 1'b0;
        end else if (reset_time) begin
          hb_cnt <= '0;
          pulse  <= 1'b0;
        end else if (!advance) begin
          pulse <= 1'b0;
        end else if (every == '0) begin
          hb_cnt <= '0;
          pulse  <= 1'b0;
        end else if (hb_cnt >= every - 1'b1) begin
          hb_cnt <= '0;
          pulse  <= 1'b1;
        end else begin
          hb_cnt <= hb_cnt + 1'b1;
          pulse  <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_time_mgr_multi_hb.sv
// Directed bench for time_mgr_multi_hb: expected unit pulses are queued ahead and popped as the DUT emits them.
module tb_time_mgr_multi_hb;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] unit_len;
  logic        reset_time;
  logic [47:0] pc_time_elapsed;
  logic [63:0] hb_every;
  logic        unit_pulse;
  logic [47:0] time_elapsed;
  logic [3:0]  hb_pulse;
  logic        stall_dn;
`ifdef TIME_MGR_SLACK_EN
  logic [47:0] max_lead;
`endif

  always #5 clk = ~clk;

  time_mgr_multi_hb dut (
    .clk             (clk),
    .reset           (reset),
    .unit_len        (unit_len),
    .reset_time      (reset_time),
    .pc_time_elapsed (pc_time_elapsed),
`ifdef TIME_MGR_SLACK_EN
    .max_lead        (max_lead),
`endif
    .hb_every        (hb_every),
    .unit_pulse      (unit_pulse),
    .time_elapsed    (time_elapsed),
    .hb_pulse        (hb_pulse),
    .stall_dn        (stall_dn)
  );

  typedef struct {
    logic [47:0] t;
    logic [3:0]  hb;
    int          gap;
  } rec_t;

  rec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cycle = 0;
  int   last_pulse = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // channel 0 has period 4, channel 1 period 3, channels 3:2 disabled
  function automatic logic [3:0] exp_hb(input int t);
    logic [3:0] r;
    r = 4'b0000;
    r[0] = (t % 4 == 0);
    r[1] = (t % 3 == 0);
    return r;
  endfunction

  task automatic push_range(input int from, input int upto, input int first_gap, input int gap);
    for (int t = from; t <= upto; t++) begin
      rec_t r;
      r.t   = 48'(t);
      r.hb  = exp_hb(t);
      r.gap = (t == from) ? first_gap : gap;
      q.push_back(r);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    if (unit_pulse) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 64'(unit_pulse), 64'd0);
      end else begin
        rec_t r;
        r = q.pop_front();
        chk("pulse_time", 64'(time_elapsed), 64'(r.t));
        chk("pulse_hb", 64'(hb_pulse), 64'(r.hb));
        chk("pulse_stall", 64'(stall_dn), 64'd0);
        if (r.gap != 0) chk("pulse_gap", 64'(cycle - last_pulse), 64'(r.gap));
        $display("pulse t=%0d hb=%b cycle=%0d", time_elapsed, hb_pulse, cycle);
        last_pulse = cycle;
      end
    end else if (hb_pulse != 4'b0000) begin
      chk("hb_without_unit", 64'(hb_pulse), 64'd0);
    end
  endtask

  task automatic run_pulses(input int bound);
    for (int i = 0; i < bound && q.size() != 0; i++) tick();
    chk("queue_drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    reset           = 1'b1;
    unit_len        = 16'd8;
    reset_time      = 1'b0;
    pc_time_elapsed = 48'd1000;
    hb_every        = {16'd0, 16'd0, 16'd3, 16'd4};
`ifdef TIME_MGR_SLACK_EN
    max_lead        = 48'd0;
`endif
    repeat (3) tick();
    chk("reset_time_elapsed", 64'(time_elapsed), 64'd0);
    chk("reset_unit_pulse", 64'(unit_pulse), 64'd0);
    chk("reset_hb", 64'(hb_pulse), 64'd0);
    chk("reset_stall", 64'(stall_dn), 64'd1);
    reset = 1'b0;

    // free-running units of 8 clocks with heartbeats
    push_range(1, 12, 0, 8);
    run_pulses(200);

    // reset_time in the middle of a unit
    repeat (3) tick();
    reset_time = 1'b1;
    tick();
    reset_time = 1'b0;
    chk("rt_mid_time", 64'(time_elapsed), 64'd0);
    chk("rt_mid_pulse", 64'(unit_pulse), 64'd0);
    chk("rt_mid_hb", 64'(hb_pulse), 64'd0);
    chk("rt_mid_stall", 64'(stall_dn), 64'd0);
    push_range(1, 10, 0, 8);
    run_pulses(200);

    // reset_time coincident with the terminal count at time 10
    repeat (7) tick();
    reset_time = 1'b1;
    tick();
    reset_time = 1'b0;
    chk("rt_term_time", 64'(time_elapsed), 64'd0);
    chk("rt_term_pulse", 64'(unit_pulse), 64'd0);
    chk("rt_term_hb", 64'(hb_pulse), 64'd0);
    push_range(1, 3, 0, 8);
    run_pulses(100);

    // throttle against PC time
    unit_len        = 16'd4;
    pc_time_elapsed = 48'd5;
    reset_time      = 1'b1;
    tick();
    reset_time = 1'b0;
    push_range(1, 5, 0, 4);
    run_pulses(100);
    repeat (20) tick();
    chk("stall_time", 64'(time_elapsed), 64'd5);
    chk("stall_flag", 64'(stall_dn), 64'd1);
    chk("stall_no_pulse", 64'(unit_pulse), 64'd0);
    pc_time_elapsed = 48'd6;
    push_range(6, 6, 0, 0);
    tick();
    chk("release_latency", 64'(q.size()), 64'd0);
    repeat (3) tick();
    chk("post_release_stall", 64'(stall_dn), 64'd0);
    tick();
    chk("restall", 64'(stall_dn), 64'd1);
    chk("restall_time", 64'(time_elapsed), 64'd6);

    // asynchronous reset between edges while in HOLD
    #2;
    reset = 1'b1;
    #1;
    chk("async_time", 64'(time_elapsed), 64'd0);
    chk("async_stall", 64'(stall_dn), 64'd1);
    chk("async_pulse", 64'(unit_pulse), 64'd0);
    chk("async_hb", 64'(hb_pulse), 64'd0);
    unit_len        = 16'd0;
    pc_time_elapsed = 48'd1000;
    #1;
    reset = 1'b0;

    // unit_len 0 then 1: a unit every clock
    push_range(1, 6, 0, 1);
    run_pulses(50);
    unit_len = 16'd1;
    push_range(7, 12, 1, 1);
    run_pulses(50);

`ifdef TIME_MGR_SLACK_EN
    // bounded run-ahead past PC time
    unit_len        = 16'd4;
    pc_time_elapsed = 48'd5;
    max_lead        = 48'd3;
    reset_time      = 1'b1;
    tick();
    reset_time = 1'b0;
    push_range(1, 8, 0, 4);
    run_pulses(100);
    repeat (20) tick();
    chk("slack_time", 64'(time_elapsed), 64'd8);
    chk("slack_stall", 64'(stall_dn), 64'd1);
    pc_time_elapsed = 48'd6;
    push_range(9, 9, 0, 0);
    run_pulses(10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
